// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared Sysbus tag field positions, line geometry and responder states.
package sysbus_pkg;
    localparam int TAG_WRITE_BIT = 12;
    localparam int TAG_TYPE_MSB = 11;
    localparam int TAG_TYPE_LSB = 8;
    localparam int TAG_ID_MSB = 7;
    localparam int TAG_ID_LSB = 0;
    localparam int BEATS_PER_LINE = 8;
    typedef enum logic [1:0] {IDLE, WDATA, WAIT, RBURST} resp_state_t;
endpackage

// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if: Sysbus request/response handshake bundle between initiator and memory.
interface sysbus_mem_responder_if #(parameter int BUS_DATA_WIDTH = 64, parameter int BUS_TAG_WIDTH = 13);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    modport master (output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
                    input bus_reqack, bus_respcyc, bus_resp, bus_resptag);
    modport slave (input bus_reqcyc, bus_req, bus_reqtag, bus_respack,
                   output bus_reqack, bus_respcyc, bus_resp, bus_resptag);
endinterface

// File: rtl/sysbus_line_ram.sv
// sysbus_line_ram: word array with synchronous write and asynchronous read, contents not reset.
module sysbus_line_ram #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [BUS_DATA_WIDTH-1:0]    wdata,
    output logic [BUS_DATA_WIDTH-1:0]    rdata
);
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus memory responder, 64-byte line reads/writes, one transaction at a time.
// Define SYSBUS_RESP_CRITWORD_EN for critical-word-first read bursts.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH = 13,
    parameter int MEM_WORDS = 4096,
    parameter int RESP_LATENCY = 4
) (
    input logic clk,
    input logic reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS_PER_LINE);
    localparam int LW = AW - BW;
    localparam int CW = RESP_LATENCY > 1 ? $clog2(RESP_LATENCY) : 1;
    resp_state_t               state;
    logic [LW-1:0]             line;
    logic [BW-1:0]             beat, first, nxt, start;
    logic [CW-1:0]             lat;
    logic [BUS_TAG_WIDTH-1:0]  tag;
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic                      we;
    assign bus.bus_reqack = bus.bus_reqcyc && (state == IDLE || state == WDATA) && !reset;
    assign nxt = beat + 1'b1;
    assign we = state == WDATA && bus.bus_reqack;
`ifdef SYSBUS_RESP_CRITWORD_EN
    assign start = bus.bus_req[5:3];
`else
    assign start = '0;
`endif
    // In a burst the array is already addressed at the following beat so the next word registers on the transfer edge.
    sysbus_line_ram #(.BUS_DATA_WIDTH(BUS_DATA_WIDTH), .MEM_WORDS(MEM_WORDS)) u_ram (
        .clk(clk),
        .we(we),
        .addr({line, state == RBURST ? nxt : beat}),
        .wdata(bus.bus_req),
        .rdata(rdata)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            line <= '0;
            beat <= '0;
            first <= '0;
            lat <= '0;
            tag <= '0;
            bus.bus_respcyc <= 1'b0;
            bus.bus_resp <= '0;
            bus.bus_resptag <= '0;
        end else begin
            case (state)
                IDLE:
                    if (bus.bus_reqack) begin
                        line <= bus.bus_req[AW+2:6];
                        tag <= bus.bus_reqtag;
                        if (bus.bus_reqtag[TAG_WRITE_BIT]) begin
                            state <= WDATA;
                            beat <= '0;
                            first <= '0;
                        end else begin
                            state <= WAIT;
                            lat <= CW'(RESP_LATENCY - 1);
                            beat <= start;
                            first <= start;
                        end
                    end
                WDATA:
                    if (bus.bus_reqack) begin
                        beat <= nxt;
                        if (beat == BW'(BEATS_PER_LINE - 1)) state <= IDLE;
                    end
                WAIT:
                    if (lat == '0) begin
                        state <= RBURST;
                        bus.bus_respcyc <= 1'b1;
                        bus.bus_resp <= rdata;
                        bus.bus_resptag <= tag;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                RBURST:
                    // Burst ends once the beat after the current one would wrap back to the first.
                    if (bus.bus_respack) begin
                        if (nxt == first) begin
                            state <= IDLE;
                            bus.bus_respcyc <= 1'b0;
                        end else begin
                            beat <= nxt;
                            bus.bus_resp <= rdata;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed scoreboard bench for sysbus_mem_responder.
module tb_sysbus_mem_responder;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int LAT = 4;
    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    sysbus_mem_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();
    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(4096), .RESP_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );
    int checks = 0;
    int errors = 0;
    int beat_seen = 0;
    int stall_beat = -1;
    int stall_left = 0;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: owns respack, pops the scoreboard on every accepted response beat.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset || !bif.bus_respcyc) begin
            bif.bus_respack = 1'b1;
        end else if (stall_left > 0 && beat_seen == stall_beat) begin
            bif.bus_respack = 1'b0;
            stall_left--;
            chk("stall_respcyc", {63'd0, bif.bus_respcyc}, 64'd1);
            if (q.size() > 0) chk("stall_hold_data", bif.bus_resp, q[0].d);
        end else begin
            bif.bus_respack = 1'b1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data %h with nothing expected", bif.bus_resp);
            end else begin
                e = q.pop_front();
                if (bif.bus_resp !== e.d || bif.bus_resptag !== e.t) begin
                    errors++;
                    $display("FAIL beat: got data %h tag %h expected data %h tag %h",
                             bif.bus_resp, bif.bus_resptag, e.d, e.t);
                end
                beat_seen++;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [12:0] t);
        int n = 0;
        @(negedge clk);
        bif.bus_reqcyc = 1'b1;
        bif.bus_req = d;
        bif.bus_reqtag = t;
        #1;
        while (!bif.bus_reqack && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL req_timeout: no reqack for data %h tag %h", d, t);
        end
        chk("accept_not_busy", {63'd0, bif.bus_respcyc}, 64'd0);
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        bif.bus_reqcyc = 1'b0;
    endtask

    task automatic push_line(input logic [63:0] base, input int start, input logic [12:0] t);
        for (int i = 0; i < 8; i++) q.push_back('{base + 64'((start + i) % 8), t});
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [12:0] t, input logic [63:0] base);
        send(addr, t);
        for (int i = 0; i < 8; i++) send(base + 64'(i), t);
        drop();
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [12:0] t, input logic [63:0] base, input int start);
        beat_seen = 0;
        push_line(base, start, t);
        send(addr, t);
        drop();
        drain();
    endtask

    initial begin
        int n;
        bif.bus_reqcyc = 1'b1;
        bif.bus_req = 64'h1000;
        bif.bus_reqtag = 13'h0105;
        #12;
        chk("reset_reqack", {63'd0, bif.bus_reqack}, 64'd0);
        chk("reset_respcyc", {63'd0, bif.bus_respcyc}, 64'd0);
        chk("reset_resp", bif.bus_resp, 64'd0);
        chk("reset_resptag", {51'd0, bif.bus_resptag}, 64'd0);
        @(negedge clk);
        bif.bus_reqcyc = 1'b0;
        reset = 1'b0;

        // Write then read with latency measurement
        write_line(64'h1000, 13'h1005, 64'hA0);
        beat_seen = 0;
        push_line(64'hA0, 0, 13'h0105);
        send(64'h1000, 13'h0105);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bif.bus_respcyc && n < 20);
        chk("first_beat_edges_after_addr", 64'(n), 64'(LAT));
        drop();
        drain();
        chk("read1_beats", 64'(beat_seen), 64'd8);

        // Address wrap plus respack stall on beat 2
        write_line(64'h8040, 13'h1006, 64'hB0);
        stall_beat = 2;
        stall_left = 3;
        read_line(64'h0040, 13'h0107, 64'hB0, 0);
        chk("stall_consumed", 64'(stall_left), 64'd0);
        chk("stall_read_beats", 64'(beat_seen), 64'd8);
        stall_beat = -1;

        // Busy rejection: second read issued during the first burst
        beat_seen = 0;
        push_line(64'hA0, 0, 13'h0110);
        send(64'h1000, 13'h0110);
        drop();
        n = 0;
        while (!bif.bus_respcyc && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_burst_started", {63'd0, bif.bus_respcyc}, 64'd1);
        push_line(64'hB0, 0, 13'h0111);
        send(64'h0040, 13'h0111);
        chk("busy_accept_after_8_beats", 64'(beat_seen), 64'd8);
        drop();
        drain();
        chk("busy_total_beats", 64'(beat_seen), 64'd16);

        // Reset asserted mid-burst at beat 4
        beat_seen = 0;
        push_line(64'hA0, 0, 13'h0120);
        send(64'h1000, 13'h0120);
        drop();
        n = 0;
        while (beat_seen != 4 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("reached_beat4", 64'(beat_seen), 64'd4);
        bif.bus_reqcyc = 1'b1;
        reset = 1'b1;
        #1;
        chk("midreset_respcyc", {63'd0, bif.bus_respcyc}, 64'd0);
        chk("midreset_reqack", {63'd0, bif.bus_reqack}, 64'd0);
        chk("midreset_resp", bif.bus_resp, 64'd0);
        q.delete();
        @(negedge clk);
        bif.bus_reqcyc = 1'b0;
        reset = 1'b0;
        read_line(64'h0040, 13'h0121, 64'hB0, 0);
        chk("post_reset_beats", 64'(beat_seen), 64'd8);

        // Offset address: critical-word-first when enabled, otherwise offset ignored
`ifdef SYSBUS_RESP_CRITWORD_EN
        read_line(64'h1028, 13'h0130, 64'hA0, 5);
`else
        read_line(64'h1028, 13'h0130, 64'hA0, 0);
`endif
        chk("offset_read_beats", 64'(beat_seen), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
